// File: rtl/dat_split_pkg.sv
// Shared types and elaboration helpers for dat_split_streamer.
// State encoding plus width derivation and sanity-check functions.
package dat_split_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int num_sub(input int win, input int wout);
    return win / wout;
  endfunction

  function automatic int addr_w(input int win, input int wout);
    return $clog2(win / wout);
  endfunction

  function automatic bit width_ok(input int win, input int wout);
    int n;
    if (wout <= 0) return 1'b0;
    if ((win % wout) != 0) return 1'b0;
    n = win / wout;
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dat_split_streamer.sv
// Wide-to-narrow serializer: one wide word in, selected sub-words out.
// Optional sticky wrap flag on oErr when ZION_DAT_SPLIT_WRAP_CHK_EN is defined.
module dat_split_streamer
  import dat_split_pkg::*;
#(
  parameter int WIDTH_DATA_IN  = 64,
  parameter int WIDTH_DATA_OUT = 16,
  localparam int NUM_SUB    = num_sub(WIDTH_DATA_IN, WIDTH_DATA_OUT),
  localparam int WIDTH_ADDR = addr_w(WIDTH_DATA_IN, WIDTH_DATA_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iVld,
  output logic                      oRdy,
  input  logic [WIDTH_DATA_IN-1:0]  iDat,
  input  logic [WIDTH_ADDR-1:0]     iStart,
  input  logic [WIDTH_ADDR-1:0]     iLen,
  output logic                      oVld,
  input  logic                      iRdy,
  output logic [WIDTH_DATA_OUT-1:0] oDat,
  output logic [WIDTH_ADDR-1:0]     oAddr,
`ifdef ZION_DAT_SPLIT_WRAP_CHK_EN
  output logic                      oErr,
`endif
  output logic                      oLast
);

  if (!width_ok(WIDTH_DATA_IN, WIDTH_DATA_OUT)) begin : g_bad_width
    $error("dat_split_streamer: bad WIDTH_DATA_IN/WIDTH_DATA_OUT");
  end

  state_t state;
  state_t state_nxt;

  logic [WIDTH_DATA_IN-1:0] datBuf;
  logic [WIDTH_ADDR-1:0]    ptr;
  logic [WIDTH_ADDR-1:0]    remain;

  logic [NUM_SUB-1:0][WIDTH_DATA_OUT-1:0] words;

  logic accept;
  logic beat;
  logic is_last;

  assign words   = datBuf;
  assign is_last = (state == SEND) && (remain == '0);
  assign beat    = (state == SEND) && iRdy;
  assign oRdy    = (state == IDLE) || (is_last && iRdy);
  assign accept  = iVld && oRdy;

  assign oVld  = (state == SEND);
  assign oLast = is_last;
  assign oDat  = words[ptr];
  assign oAddr = ptr;

  // Next-state: enter SEND on accept, leave after an unrefilled last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (beat && is_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word buffer and beat counters: load on accept, step on non-last beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      datBuf <= '0;
      ptr    <= '0;
      remain <= '0;
    end else if (accept) begin
      datBuf <= iDat;
      ptr    <= iStart;
      remain <= iLen;
    end else if (beat && !is_last) begin
      ptr    <= ptr + WIDTH_ADDR'(1);
      remain <= remain - WIDTH_ADDR'(1);
    end
  end

`ifdef ZION_DAT_SPLIT_WRAP_CHK_EN
  logic [WIDTH_ADDR:0] span;
  logic                wrap;

  assign span = {1'b0, iStart} + {1'b0, iLen};
  assign wrap = span > (WIDTH_ADDR + 1)'(NUM_SUB - 1);

  // Sticky flag for any accepted word whose beats run past the top sub-word.
  always_ff @(posedge clk) begin
    if (rst)                oErr <= 1'b0;
    else if (accept && wrap) oErr <= 1'b1;
  end
`endif

endmodule
